// File: rtl/rename_nway.sv
// ============================================================================
// rename_nway
//   N-wide register-rename stage between decode and dispatch. It holds the
//   speculative rename table (RAT), the committed rename table (ARAT) and a
//   circular freelist of physical registers. A group of up to WIDTH
//   instructions is renamed per cycle into a one-deep output register.
//   Retiring instructions update the ARAT and return their old physical
//   register to the freelist. A flush restores the RAT and freelist head
//   from the committed state.
//
// Ports
//   clock, reset       clock; asynchronous active-high reset
//   flush              redirect: discard in-flight renames, restore from ARAT
//   in_valid/in_ready  per-slot valid; the whole group is taken on
//                      (|in_valid && in_ready)
//   in_need_wb         slot writes its logical destination
//   in_lrs1/2, in_lrd  logical registers, slot i at [i*LREG_W +: LREG_W]
//   out_valid          registered per-slot valid; out_ready takes the group
//   out_prs1/2         renamed sources
//   out_prd            newly allocated destination (0 if no allocation)
//   out_old_prd        previous mapping of the logical destination
//   commit_valid       per commit port: retiring instruction wrote lrd
//   commit_lrd/prd     mapping entering the ARAT
//   commit_old_prd     physical register returned to the freelist tail
// ============================================================================
module rename_nway #(
    parameter int  WIDTH    = 2,
    parameter int  COMMIT_W = 2,
    parameter int  LREGS    = 32,
    parameter int  PREGS    = 64,
    localparam int LREG_W   = $clog2(LREGS),
    localparam int PREG_W   = $clog2(PREGS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_need_wb,
    input  logic [WIDTH*LREG_W-1:0]      in_lrs1,
    input  logic [WIDTH*LREG_W-1:0]      in_lrs2,
    input  logic [WIDTH*LREG_W-1:0]      in_lrd,
    output logic [WIDTH-1:0]             out_valid,
    input  logic                         out_ready,
    output logic [WIDTH*PREG_W-1:0]      out_prs1,
    output logic [WIDTH*PREG_W-1:0]      out_prs2,
    output logic [WIDTH*PREG_W-1:0]      out_prd,
    output logic [WIDTH*PREG_W-1:0]      out_old_prd,
    input  logic [COMMIT_W-1:0]          commit_valid,
    input  logic [COMMIT_W*LREG_W-1:0]   commit_lrd,
    input  logic [COMMIT_W*PREG_W-1:0]   commit_prd,
    input  logic [COMMIT_W*PREG_W-1:0]   commit_old_prd
);

    localparam int FL_DEPTH = PREGS - LREGS;
    localparam int FL_W     = $clog2(FL_DEPTH);
    // Freelist pointers carry one extra wrap bit so full and empty differ.
    localparam int PTR_W    = FL_W + 1;

    // ------------------------------------------------------------------
    // Field extraction helpers
    // ------------------------------------------------------------------
    function automatic logic [LREG_W-1:0] slot_lreg(input logic [WIDTH*LREG_W-1:0] vec,
                                                    input int slot);
        return vec[slot*LREG_W +: LREG_W];
    endfunction

    function automatic logic [LREG_W-1:0] port_lreg(input logic [COMMIT_W*LREG_W-1:0] vec,
                                                    input int port);
        return vec[port*LREG_W +: LREG_W];
    endfunction

    function automatic logic [PREG_W-1:0] port_preg(input logic [COMMIT_W*PREG_W-1:0] vec,
                                                    input int port);
        return vec[port*PREG_W +: PREG_W];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PREG_W-1:0]        rat  [LREGS];
    logic [PREG_W-1:0]        arat [LREGS];
    logic [PREG_W-1:0]        fl   [FL_DEPTH];
    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic [PTR_W-1:0]         commit_head;

    logic [WIDTH-1:0]         vld_p1;
    logic [WIDTH*PREG_W-1:0]  prs1_p1;
    logic [WIDTH*PREG_W-1:0]  prs2_p1;
    logic [WIDTH*PREG_W-1:0]  prd_p1;
    logic [WIDTH*PREG_W-1:0]  old_prd_p1;

    // ------------------------------------------------------------------
    // Combinational rename of the incoming group
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]         alloc;
    logic [PTR_W-1:0]         n_alloc;
    logic [FL_W-1:0]          alloc_idx [WIDTH];
    logic [PREG_W-1:0]        new_prd   [WIDTH];
    logic [PREG_W-1:0]        prs1_c    [WIDTH];
    logic [PREG_W-1:0]        prs2_c    [WIDTH];
    logic [PREG_W-1:0]        old_c     [WIDTH];
    logic [WIDTH*PREG_W-1:0]  prs1_pk;
    logic [WIDTH*PREG_W-1:0]  prs2_pk;
    logic [WIDTH*PREG_W-1:0]  prd_pk;
    logic [WIDTH*PREG_W-1:0]  old_pk;
    logic [PTR_W-1:0]         free_count;
    logic                     accept;

    // Each allocating slot takes the next freelist entry after those taken
    // by older slots in the same group.
    always_comb begin
        alloc   = '0;
        n_alloc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            alloc[i]     = in_valid[i] & in_need_wb[i] & (slot_lreg(in_lrd, i) != '0);
            alloc_idx[i] = head[FL_W-1:0] + n_alloc[FL_W-1:0];
            new_prd[i]   = alloc[i] ? fl[alloc_idx[i]] : '0;
            n_alloc      = n_alloc + PTR_W'(alloc[i]);
        end
    end

    // Sources and old destination read the RAT, overridden by the youngest
    // older slot of the same group that writes the same logical register.
    always_comb begin
        prs1_pk = '0;
        prs2_pk = '0;
        prd_pk  = '0;
        old_pk  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prs1_c[i] = rat[slot_lreg(in_lrs1, i)];
            prs2_c[i] = rat[slot_lreg(in_lrs2, i)];
            old_c[i]  = rat[slot_lreg(in_lrd, i)];
            for (int j = 0; j < i; j++) begin
                if (alloc[j] && slot_lreg(in_lrd, j) == slot_lreg(in_lrs1, i))
                    prs1_c[i] = new_prd[j];
                if (alloc[j] && slot_lreg(in_lrd, j) == slot_lreg(in_lrs2, i))
                    prs2_c[i] = new_prd[j];
                if (alloc[j] && slot_lreg(in_lrd, j) == slot_lreg(in_lrd, i))
                    old_c[i] = new_prd[j];
            end
            prs1_pk[i*PREG_W +: PREG_W] = prs1_c[i];
            prs2_pk[i*PREG_W +: PREG_W] = prs2_c[i];
            prd_pk[i*PREG_W +: PREG_W]  = new_prd[i];
            old_pk[i*PREG_W +: PREG_W]  = old_c[i];
        end
    end

    assign free_count = tail - head;
    assign in_ready   = !flush && ((vld_p1 == '0) || out_ready) && (free_count >= n_alloc);
    assign accept     = in_ready && (in_valid != '0);

    // ------------------------------------------------------------------
    // Combinational commit: ARAT update and freelist push slots
    // ------------------------------------------------------------------
    logic [PREG_W-1:0]        arat_next [LREGS];
    logic [COMMIT_W-1:0]      push_en;
    logic [FL_W-1:0]          push_idx  [COMMIT_W];
    logic [PTR_W-1:0]         n_push;

    // Later (younger) ports overwrite earlier ones on the same lrd.
    always_comb begin
        arat_next = arat;
        push_en   = '0;
        n_push    = '0;
        for (int p = 0; p < COMMIT_W; p++) begin
            push_en[p]  = commit_valid[p] & (port_lreg(commit_lrd, p) != '0);
            push_idx[p] = tail[FL_W-1:0] + n_push[FL_W-1:0];
            if (push_en[p])
                arat_next[port_lreg(commit_lrd, p)] = port_preg(commit_prd, p);
            n_push = n_push + PTR_W'(push_en[p]);
        end
    end

    // ------------------------------------------------------------------
    // Stage boundary: rename tables, freelist and output register (_p1)
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < LREGS; l++) begin
                rat[l]  <= PREG_W'(l);
                arat[l] <= PREG_W'(l);
            end
            for (int k = 0; k < FL_DEPTH; k++)
                fl[k] <= PREG_W'(LREGS + k);
            head        <= '0;
            commit_head <= '0;
            tail        <= PTR_W'(FL_DEPTH);
            vld_p1      <= '0;
            prs1_p1     <= '0;
            prs2_p1     <= '0;
            prd_p1      <= '0;
            old_prd_p1  <= '0;
        end else begin
            arat <= arat_next;
            for (int p = 0; p < COMMIT_W; p++)
                if (push_en[p])
                    fl[push_idx[p]] <= port_preg(commit_old_prd, p);
            tail        <= tail + n_push;
            commit_head <= commit_head + n_push;

            if (flush) begin
                // Same-cycle commits are already folded into arat_next.
                head   <= commit_head + n_push;
                rat    <= arat_next;
                vld_p1 <= '0;
            end else if (accept) begin
                head <= head + n_alloc;
                for (int i = 0; i < WIDTH; i++)
                    if (alloc[i])
                        rat[slot_lreg(in_lrd, i)] <= new_prd[i];
                vld_p1     <= in_valid;
                prs1_p1    <= prs1_pk;
                prs2_p1    <= prs2_pk;
                prd_p1     <= prd_pk;
                old_prd_p1 <= old_pk;
            end else if (out_ready) begin
                vld_p1     <= '0;
                prs1_p1    <= '0;
                prs2_p1    <= '0;
                prd_p1     <= '0;
                old_prd_p1 <= '0;
            end
        end
    end

    assign out_valid   = vld_p1;
    assign out_prs1    = prs1_p1;
    assign out_prs2    = prs2_p1;
    assign out_prd     = prd_p1;
    assign out_old_prd = old_prd_p1;

endmodule

// File: tb/tb_rename_nway.sv
// ============================================================================
// tb_rename_nway
//   Directed bench for rename_nway (WIDTH=2, COMMIT_W=2, LREGS=32, PREGS=64).
//   Expected values are hand-computed from the rename rules.
// ============================================================================
module tb_rename_nway;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [1:0]  in_valid;
    logic        in_ready;
    logic [1:0]  in_need_wb;
    logic [9:0]  in_lrs1;
    logic [9:0]  in_lrs2;
    logic [9:0]  in_lrd;
    logic [1:0]  out_valid;
    logic        out_ready;
    logic [11:0] out_prs1;
    logic [11:0] out_prs2;
    logic [11:0] out_prd;
    logic [11:0] out_old_prd;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_lrd;
    logic [11:0] commit_prd;
    logic [11:0] commit_old_prd;

    int checks = 0;
    int errors = 0;

    rename_nway #(.WIDTH(2), .COMMIT_W(2), .LREGS(32), .PREGS(64)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_need_wb     (in_need_wb),
        .in_lrs1        (in_lrs1),
        .in_lrs2        (in_lrs2),
        .in_lrd         (in_lrd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_prs1       (out_prs1),
        .out_prs2       (out_prs2),
        .out_prd        (out_prd),
        .out_old_prd    (out_old_prd),
        .commit_valid   (commit_valid),
        .commit_lrd     (commit_lrd),
        .commit_prd     (commit_prd),
        .commit_old_prd (commit_old_prd)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Freelist occupancy must never exceed its depth.
    always @(negedge clock)
        if (!reset) assert (dut.free_count <= 6'd32) else $error("freelist overflow");

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] f(input logic [11:0] v, input int s);
        return v[s*6 +: 6];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input logic [1:0] v, input logic [1:0] wb,
                       input int a1, input int a2, input int ad,
                       input int b1, input int b2, input int bd);
        in_valid   = v;
        in_need_wb = wb;
        in_lrs1    = {5'(b1), 5'(a1)};
        in_lrs2    = {5'(b2), 5'(a2)};
        in_lrd     = {5'(bd), 5'(ad)};
    endtask

    task automatic idle();
        drv(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        flush          = 1'b0;
        out_ready      = 1'b1;
        commit_valid   = '0;
        commit_lrd     = '0;
        commit_prd     = '0;
        commit_old_prd = '0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        idle();
        flush = 1'b0;
        out_ready = 1'b1;
        commit_valid = '0;
        commit_lrd = '0;
        commit_prd = '0;
        commit_old_prd = '0;

        // ---------------- 1: reset state, intra-group bypass ----------------
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_prd", 32'(out_prd), 0);
        chk("rst_out_prs1", 32'(out_prs1), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        drv(2'b11, 2'b11, 5, 0, 5, 5, 0, 5);
        tick();
        chk("t1_valid", 32'(out_valid), 3);
        chk("t1_s0_prs1", 32'(f(out_prs1, 0)), 5);
        chk("t1_s0_prd", 32'(f(out_prd, 0)), 32);
        chk("t1_s0_old", 32'(f(out_old_prd, 0)), 5);
        chk("t1_s1_prs1", 32'(f(out_prs1, 1)), 32);
        chk("t1_s1_prd", 32'(f(out_prd, 1)), 33);
        chk("t1_s1_old", 32'(f(out_old_prd, 1)), 32);
        drv(2'b01, 2'b00, 5, 0, 0, 0, 0, 0);
        tick();
        chk("t1_rat5", 32'(f(out_prs1, 0)), 33);
        chk("t1_noalloc_prd", 32'(f(out_prd, 0)), 0);

        // ---------------- 2: freelist exhaustion and commit refill ----------
        do_reset();
        for (int g = 0; g < 16; g++) begin
            drv(2'b11, 2'b11, 0, 0, 1, 0, 0, 2);
            tick();
        end
        chk("t2_last_s0_prd", 32'(f(out_prd, 0)), 62);
        chk("t2_last_s1_prd", 32'(f(out_prd, 1)), 63);
        drv(2'b11, 2'b11, 0, 0, 1, 0, 0, 2);
        #1;
        chk("t2_empty_ready", 32'(in_ready), 0);
        commit_valid   = 2'b01;
        commit_lrd     = {5'd0, 5'd1};
        commit_prd     = {6'd0, 6'd32};
        commit_old_prd = {6'd0, 6'd7};
        tick();
        commit_valid = '0;
        #1;
        chk("t2_two_still_stalled", 32'(in_ready), 0);
        chk("t2_out_cleared", 32'(out_valid), 0);
        drv(2'b11, 2'b01, 0, 0, 3, 0, 0, 4);
        #1;
        chk("t2_one_ready", 32'(in_ready), 1);
        tick();
        chk("t2_refill_prd", 32'(f(out_prd, 0)), 7);
        chk("t2_refill_s1_prd", 32'(f(out_prd, 1)), 0);
        chk("t2_refill_valid", 32'(out_valid), 3);
        #1;
        chk("t2_empty_again", 32'(in_ready), 0);

        // ---------------- 3: output backpressure ---------------------------
        do_reset();
        drv(2'b11, 2'b11, 1, 0, 4, 2, 0, 6);
        tick();
        out_ready = 1'b0;
        drv(2'b11, 2'b11, 0, 0, 7, 0, 0, 8);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t3_stall_ready", 32'(in_ready), 0);
            tick();
            chk("t3_hold_s0_prd", 32'(f(out_prd, 0)), 32);
            chk("t3_hold_s1_prd", 32'(f(out_prd, 1)), 33);
            chk("t3_hold_valid", 32'(out_valid), 3);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_release_ready", 32'(in_ready), 1);
        tick();
        chk("t3_next_s0_prd", 32'(f(out_prd, 0)), 34);
        chk("t3_next_s1_prd", 32'(f(out_prd, 1)), 35);

        // ---------------- 4: flush without commits -------------------------
        do_reset();
        drv(2'b11, 2'b11, 0, 0, 1, 0, 0, 2);
        tick();
        drv(2'b11, 2'b11, 0, 0, 3, 0, 0, 4);
        tick();
        drv(2'b11, 2'b11, 0, 0, 5, 0, 0, 6);
        tick();
        flush = 1'b1;
        drv(2'b11, 2'b11, 0, 0, 7, 0, 0, 8);
        #1;
        chk("t4_flush_ready", 32'(in_ready), 0);
        tick();
        flush = 1'b0;
        chk("t4_flush_valid", 32'(out_valid), 0);
        drv(2'b11, 2'b11, 1, 5, 9, 6, 0, 10);
        tick();
        chk("t4_s0_prs1", 32'(f(out_prs1, 0)), 1);
        chk("t4_s0_prs2", 32'(f(out_prs2, 0)), 5);
        chk("t4_s0_prd", 32'(f(out_prd, 0)), 32);
        chk("t4_s1_prs1", 32'(f(out_prs1, 1)), 6);
        chk("t4_s1_prd", 32'(f(out_prd, 1)), 33);

        // ---------------- 5: lrd 0 never allocates -------------------------
        do_reset();
        drv(2'b11, 2'b11, 0, 0, 0, 0, 0, 3);
        tick();
        chk("t5_s0_prd", 32'(f(out_prd, 0)), 0);
        chk("t5_s0_old", 32'(f(out_old_prd, 0)), 0);
        chk("t5_s1_prd", 32'(f(out_prd, 1)), 32);
        drv(2'b01, 2'b01, 0, 3, 3, 0, 0, 0);
        tick();
        chk("t5_rat0", 32'(f(out_prs1, 0)), 0);
        chk("t5_rat3", 32'(f(out_prs2, 0)), 32);
        chk("t5_head_plus1", 32'(f(out_prd, 0)), 33);
        chk("t5_old3", 32'(f(out_old_prd, 0)), 32);

        // ---------------- 6: flush with same-cycle commit ------------------
        do_reset();
        drv(2'b01, 2'b01, 0, 0, 5, 0, 0, 0);
        tick();
        idle();
        flush          = 1'b1;
        commit_valid   = 2'b01;
        commit_lrd     = {5'd0, 5'd5};
        commit_prd     = {6'd0, 6'd32};
        commit_old_prd = {6'd0, 6'd5};
        tick();
        flush        = 1'b0;
        commit_valid = '0;
        chk("t6_flush_valid", 32'(out_valid), 0);
        drv(2'b11, 2'b11, 5, 0, 5, 0, 0, 6);
        #1;
        chk("t6_ready", 32'(in_ready), 1);
        tick();
        chk("t6_rat5", 32'(f(out_prs1, 0)), 32);
        chk("t6_old5", 32'(f(out_old_prd, 0)), 32);
        chk("t6_head1_prd", 32'(f(out_prd, 0)), 33);
        chk("t6_s1_prd", 32'(f(out_prd, 1)), 34);
        for (int g = 0; g < 15; g++) begin
            drv(2'b11, 2'b11, 0, 0, 1, 0, 0, 2);
            tick();
        end
        chk("t6_wrap_s0_prd", 32'(f(out_prd, 0)), 63);
        chk("t6_freed_preg5", 32'(f(out_prd, 1)), 5);
        drv(2'b01, 2'b01, 0, 0, 1, 0, 0, 0);
        #1;
        chk("t6_full_use_ready", 32'(in_ready), 0);

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
